alu_muldiv_seq: RTL

//  Parametrised execute unit, successor to the single-cycle ALU. Covers all base ALU/branch-compare ops plus the RV32M
//  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU set. Sits in the EX stage and talks to issue and writeback over

---
 rtl/alu_muldiv_seq_pkg.sv | 41 ++++
 rtl/alu_muldiv_seq_alu_core.sv | 58 +++++
 rtl/alu_muldiv_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the sequential ALU / multiply-divide execute unit:
// base ALU op codes, M-extension funct3 codes and FSM states.
package alu_muldiv_seq_pkg;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLL  = 4'd2,
        ALU_OP_SLT  = 4'd3,
        ALU_OP_SLTU = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_OR   = 4'd8,
        ALU_OP_AND  = 4'd9,
        ALU_OP_EQ   = 4'd10,
        ALU_OP_NEQ  = 4'd11,
        ALU_OP_GE   = 4'd12,
        ALU_OP_GEU  = 4'd13
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_OP_MUL    = 3'd0,
        MD_OP_MULH   = 3'd1,
        MD_OP_MULHSU = 3'd2,
        MD_OP_MULHU  = 3'd3,
        MD_OP_DIV    = 3'd4,
        MD_OP_DIVU   = 3'd5,
        MD_OP_REM    = 3'd6,
        MD_OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIXUP,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_muldiv_seq_alu_core.sv
// Purely combinational base ALU: add/sub, compares, bidirectional shifter, logic ops.
module alu_core
    import alu_muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]    sh;
    logic              fill;
    logic              lt;
    logic              ltu;
    logic [XLEN-1:0]   shin;
    logic [XLEN-1:0]   shr;
    logic [XLEN-1:0]   shl;
    logic [2*XLEN-1:0] ext;

    always_comb begin
        sh   = b[SHW-1:0];
        fill = (op == ALU_OP_SRA) && a[XLEN-1];
        // Left shifts reuse the right shifter on the bit-reversed operand.
        for (int unsigned i = 0; i < XLEN; i++) begin
            shin[i] = (op == ALU_OP_SLL) ? a[XLEN-1-i] : a[i];
        end
        ext = {{XLEN{fill}}, shin};
        shr = XLEN'(ext >> sh);
        for (int unsigned i = 0; i < XLEN; i++) begin
            shl[i] = shr[XLEN-1-i];
        end
        ltu = (a < b);
        lt  = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : ltu;

        y = '0;
        case (alu_op_e'(op))
            ALU_OP_ADD:  y = a + b;
            ALU_OP_SUB:  y = a - b;
            ALU_OP_SLL:  y = shl;
            ALU_OP_SLT:  y = {{(XLEN-1){1'b0}}, lt};
            ALU_OP_SLTU: y = {{(XLEN-1){1'b0}}, ltu};
            ALU_OP_XOR:  y = a ^ b;
            ALU_OP_SRL:  y = shr;
            ALU_OP_SRA:  y = shr;
            ALU_OP_OR:   y = a | b;
            ALU_OP_AND:  y = a & b;
            ALU_OP_EQ:   y = {{(XLEN-1){1'b0}}, (a == b)};
            ALU_OP_NEQ:  y = {{(XLEN-1){1'b0}}, (a != b)};
            ALU_OP_GE:   y = {{(XLEN-1){1'b0}}, !lt};
            ALU_OP_GEU:  y = {{(XLEN-1){1'b0}}, !ltu};
            default:     y = '0;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// EX-stage execute unit: single-cycle base ALU ops plus iterative radix-2
// RV32M multiply/divide, with valid/ready handshakes on both sides.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);

    state_e            state, state_n;
    md_op_e            md_op, md_op_n;
    logic [XLEN-1:0]   opa, opa_n;
    logic [XLEN-1:0]   opb, opb_n;
    logic [XLEN-1:0]   rem, rem_n;
    logic [2*XLEN-1:0] acc, acc_n;
    logic [SHW-1:0]    cnt, cnt_n;
    logic              neg, neg_n;
    logic              neg_rem, neg_rem_n;
    logic [XLEN-1:0]   out_data_n;

    logic [XLEN-1:0]   alu_y;
    logic              accept;
    logic              last;
    logic [2:0]        f3;
    logic              a_sgn, b_sgn, a_neg, b_neg, is_rem_op;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, prod;
    logic [XLEN:0]     div_sh;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    alu_core #(.XLEN(XLEN)) u_alu_core (
        .op (in_op[3:0]),
        .a  (in_a),
        .b  (in_b),
        .y  (alu_y)
    );

    assign in_ready  = !flush && (state == S_IDLE || (state == S_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_MUL) || (state == S_DIV) || (state == S_FIXUP);
    assign last      = (cnt == SHW'(XLEN-1));

    always_comb begin
        f3 = in_op[2:0];
        if (f3[2]) begin
            a_sgn = !f3[0];
            b_sgn = !f3[0];
        end else begin
            a_sgn = (f3 == MD_OP_MULH) || (f3 == MD_OP_MULHSU);
            b_sgn = (f3 == MD_OP_MULH);
        end
        a_neg = a_sgn && in_a[XLEN-1];
        b_neg = b_sgn && in_b[XLEN-1];
        a_mag = a_neg ? -in_a : in_a;
        b_mag = b_neg ? -in_b : in_b;
    end

    always_comb begin
        // Shift-add: product accumulates in the upper half, multiplier bits retire from opb.
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (opb[0] ? opa : '0)};
        mul_step = (2*XLEN)'({mul_sum, acc[XLEN-1:0]} >> 1);
        prod     = neg ? -mul_step : mul_step;
        // Restoring divide: dividend shifts out of opa while quotient bits shift in.
        div_sh   = {rem, opa[XLEN-1]};
        div_diff = {1'b0, div_sh} - {2'b00, opb};
        quo_fix  = neg ? -opa : opa;
        rem_fix  = neg_rem ? -rem : rem;
        is_rem_op = (md_op == MD_OP_REM) || (md_op == MD_OP_REMU);
    end

    always_comb begin
        state_n    = state;
        md_op_n    = md_op;
        opa_n      = opa;
        opb_n      = opb;
        rem_n      = rem;
        acc_n      = acc;
        cnt_n      = cnt;
        neg_n      = neg;
        neg_rem_n  = neg_rem;
        out_data_n = out_data;

        unique case (state)
            S_MUL: begin
                acc_n = mul_step;
                opb_n = opb >> 1;
                cnt_n = cnt + 1'b1;
                if (last) begin
                    out_data_n = (md_op == MD_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    state_n    = S_DONE;
                end
            end
            S_DIV: begin
                rem_n = XLEN'(div_diff[XLEN+1] ? {1'b0, div_sh} : div_diff);
                opa_n = {opa[XLEN-2:0], !div_diff[XLEN+1]};
                cnt_n = cnt + 1'b1;
                if (last) state_n = S_FIXUP;
            end
            S_FIXUP: begin
                out_data_n = is_rem_op ? rem_fix : quo_fix;
                state_n    = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_n = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            if (!in_op[4]) begin
                out_data_n = alu_y;
                state_n    = S_DONE;
            end else if (!f3[2]) begin
                state_n = S_MUL;
                md_op_n = md_op_e'(f3);
                opa_n   = a_mag;
                opb_n   = b_mag;
                acc_n   = '0;
                cnt_n   = '0;
                neg_n   = a_neg ^ b_neg;
            end else if (in_b == '0) begin
                out_data_n = f3[1] ? in_a : '1;
                state_n    = S_DONE;
            end else if (!f3[0] && in_a == {1'b1, {(XLEN-1){1'b0}}} && in_b == '1) begin
                out_data_n = f3[1] ? '0 : in_a;
                state_n    = S_DONE;
            end else begin
                state_n   = S_DIV;
                md_op_n   = md_op_e'(f3);
                opa_n     = a_mag;
                opb_n     = b_mag;
                rem_n     = '0;
                cnt_n     = '0;
                neg_n     = a_neg ^ b_neg;
                neg_rem_n = a_neg;
            end
        end

        if (flush) state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            md_op    <= MD_OP_MUL;
            opa      <= '0;
            opb      <= '0;
            rem      <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            neg_rem  <= 1'b0;
            out_data <= '0;
        end else begin
            state    <= state_n;
            md_op    <= md_op_n;
            opa      <= opa_n;
            opb      <= opb_n;
            rem      <= rem_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            neg      <= neg_n;
            neg_rem  <= neg_rem_n;
            out_data <= out_data_n;
        end
    end

endmodule
